// File: rtl/wormhole_switch_allocator_pkg.sv
// Shared router types: port directions, allocator FSM states and node port count.
package wormhole_switch_allocator_pkg;
    localparam int NODE_PORTS = 4;

    typedef enum logic [1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } e_dir;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } e_alloc_state;
endpackage

// File: rtl/wormhole_switch_allocator_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last owner, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = '0;
        for (int k = 1; k <= N; k++) begin
            c = IW'((int'(last) + k) % N);
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end
endmodule

// File: rtl/wormhole_switch_allocator.sv
// Switch allocator: per-output round-robin with wormhole locking until tail fire,
// registered owner table for the crossbar, and a sticky stall detector.
module wormhole_switch_allocator
    import wormhole_switch_allocator_pkg::*;
#(
    parameter int PORTS       = NODE_PORTS,
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = $clog2(STALL_LIMIT + 1),
    localparam int IW         = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         req_valid,
    input  logic [PORTS-1:0]         req_head,
    input  logic [PORTS-1:0]         req_tail,
    input  logic [PORTS-1:0][IW-1:0] req_dir,
    input  logic [PORTS-1:0]         flit_fire,
    output logic [PORTS-1:0]         grant,
    output logic [PORTS-1:0][IW-1:0] grant_dir,
    output logic [PORTS-1:0]         out_busy,
    output logic [PORTS-1:0][IW-1:0] out_owner,
    output logic                     stall_err
);
    e_alloc_state                st     [PORTS];
    e_alloc_state                st_nxt [PORTS];
    logic [PORTS-1:0][IW-1:0]    owner, owner_nxt, last, last_nxt;
    logic [PORTS-1:0][CNT_W-1:0] cnt, cnt_nxt;
    logic [PORTS-1:0][PORTS-1:0] cand, arb_gnt;
    logic [PORTS-1:0][IW-1:0]    arb_idx, grant_dir_nxt;
    logic [PORTS-1:0]            arb_any, grant_nxt;
    logic                        err_nxt;

    for (genvar o = 0; o < PORTS; o++) begin : g_out
        // inputs already holding an output cannot compete for another
        for (genvar i = 0; i < PORTS; i++) begin : g_cand
            assign cand[o][i] = req_valid[i] && req_head[i] && !grant[i] &&
                                (req_dir[i] == IW'(o));
        end
        rr_arbiter #(.N(PORTS)) u_arb (
            .req  (cand[o]),
            .last (last[o]),
            .gnt  (arb_gnt[o]),
            .idx  (arb_idx[o]),
            .any  (arb_any[o])
        );
        assign out_busy[o]  = (st[o] == LOCKED);
        assign out_owner[o] = owner[o];
    end

    always_comb begin
        st_nxt        = st;
        owner_nxt     = owner;
        last_nxt      = last;
        cnt_nxt       = cnt;
        grant_nxt     = grant;
        grant_dir_nxt = grant_dir;
        err_nxt       = stall_err;
        for (int o = 0; o < PORTS; o++) begin
            if (st[o] == LOCKED) begin
                if (cnt[o] == CNT_W'(STALL_LIMIT))
                    err_nxt = 1'b1;
                if (flit_fire[owner[o]])
                    cnt_nxt[o] = '0;
                else if (cnt[o] != CNT_W'(STALL_LIMIT))
                    cnt_nxt[o] = cnt[o] + CNT_W'(1);
                // release cycle does not arbitrate; owner cleared so the table reads NORTH
                if (flit_fire[owner[o]] && req_tail[owner[o]]) begin
                    st_nxt[o]                = FREE;
                    owner_nxt[o]             = '0;
                    grant_nxt[owner[o]]      = 1'b0;
                    grant_dir_nxt[owner[o]]  = '0;
                end
            end else begin
                cnt_nxt[o] = '0;
                if (arb_any[o]) begin
                    st_nxt[o]                  = LOCKED;
                    owner_nxt[o]               = arb_idx[o];
                    last_nxt[o]                = arb_idx[o];
                    grant_nxt                  = grant_nxt | arb_gnt[o];
                    grant_dir_nxt[arb_idx[o]]  = IW'(o);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= '{default: FREE};
            owner     <= '0;
            last      <= {PORTS{IW'(PORTS - 1)}};
            cnt       <= '0;
            grant     <= '0;
            grant_dir <= '0;
            stall_err <= 1'b0;
        end else begin
            st        <= st_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            cnt       <= cnt_nxt;
            grant     <= grant_nxt;
            grant_dir <= grant_dir_nxt;
            stall_err <= err_nxt;
        end
    end

    for (genvar i = 0; i < PORTS; i++) begin : g_chk
        a_head_tail: assert property (@(posedge clk) disable iff (rst)
            !(req_head[i] && req_tail[i]));
        a_head_granted: assert property (@(posedge clk) disable iff (rst)
            !(req_head[i] && grant[i]));
        a_fire_grant: assert property (@(posedge clk) disable iff (rst)
            !flit_fire[i] || grant[i]);
    end
endmodule
